// File: rtl/cpu_pkg.sv
// Shared definitions for the hardwired control unit: opcodes, FSM states,
// instruction classes and the bundle of datapath strobes.
package cpu_pkg;

  localparam int DATA_W = 32;
  localparam int OP_W   = 5;

  localparam logic [4:0] OP_LD   = 5'd0;
  localparam logic [4:0] OP_LDI  = 5'd1;
  localparam logic [4:0] OP_ST   = 5'd2;
  localparam logic [4:0] OP_ADD  = 5'd3;
  localparam logic [4:0] OP_SHL  = 5'd11;
  localparam logic [4:0] OP_ADDI = 5'd12;
  localparam logic [4:0] OP_ORI  = 5'd14;
  localparam logic [4:0] OP_DIV  = 5'd15;
  localparam logic [4:0] OP_MUL  = 5'd16;
  localparam logic [4:0] OP_NEG  = 5'd17;
  localparam logic [4:0] OP_NOT  = 5'd18;
  localparam logic [4:0] OP_BR   = 5'd19;
  localparam logic [4:0] OP_JR   = 5'd20;
  localparam logic [4:0] OP_JAL  = 5'd21;
  localparam logic [4:0] OP_IN   = 5'd22;
  localparam logic [4:0] OP_OUT  = 5'd23;
  localparam logic [4:0] OP_MFHI = 5'd24;
  localparam logic [4:0] OP_MFLO = 5'd25;
  localparam logic [4:0] OP_HALT = 5'd27;

  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    C_ALU3, C_ALU2, C_IMM, C_LDI, C_LD, C_ST, C_MULDIV, C_BR,
    C_JR, C_JAL, C_IN, C_OUT, C_MFHI, C_MFLO, C_NOP, C_HALT
  } class_t;

  typedef struct packed {
    logic gra, grb, grc, r_in, r_out, ba_out, c_out;
    logic pc_out, pc_in, inc_pc, ir_in, y_in, z_in, zlo_out, zhi_out;
    logic mar_in, mdr_in, mdr_out, read, write;
    logic hi_in, hi_out, lo_in, lo_out, con_in, inport_out, outport_in, r8_in;
  } ctrl_t;

  // Final execute step of each class; the FSM returns to T0 after it.
  function automatic state_t last_step(class_t c);
    case (c)
      C_ALU3, C_IMM, C_LDI: last_step = S_T5;
      C_ALU2, C_JAL:        last_step = S_T4;
      C_LD, C_ST:           last_step = S_T7;
      C_MULDIV, C_BR:       last_step = S_T6;
      default:              last_step = S_T3;
    endcase
  endfunction

  function automatic state_t succ(state_t s);
    case (s)
      S_T3:    succ = S_T4;
      S_T4:    succ = S_T5;
      S_T5:    succ = S_T6;
      S_T6:    succ = S_T7;
      default: succ = S_T0;
    endcase
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// Maps an opcode onto the execute-sequence class it shares with similar instructions.
module instr_decoder
  import cpu_pkg::*;
#(
  parameter int OP_W = 5
) (
  input  logic [OP_W-1:0] opcode,
  output class_t          cls
);

  always_comb begin
    cls = C_NOP;
    case (opcode) inside
      OP_LD:             cls = C_LD;
      OP_LDI:            cls = C_LDI;
      OP_ST:             cls = C_ST;
      [OP_ADD:OP_SHL]:   cls = C_ALU3;
      [OP_ADDI:OP_ORI]:  cls = C_IMM;
      OP_DIV, OP_MUL:    cls = C_MULDIV;
      OP_NEG, OP_NOT:    cls = C_ALU2;
      OP_BR:             cls = C_BR;
      OP_JR:             cls = C_JR;
      OP_JAL:            cls = C_JAL;
      OP_IN:             cls = C_IN;
      OP_OUT:            cls = C_OUT;
      OP_MFHI:           cls = C_MFHI;
      OP_MFLO:           cls = C_MFLO;
      OP_HALT:           cls = C_HALT;
      default:           cls = C_NOP;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired control unit: fetch T0-T2, per-class execute T3-T7, memory stalls,
// and stopping at instruction boundaries.
module control_unit
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OP_W   = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] ir,
  input  logic              con_ff,
  input  logic              mem_done,
  input  logic              stop,
  output logic              gra, grb, grc, r_in, r_out, ba_out, c_out,
  output logic              pc_out, pc_in, inc_pc, ir_in, y_in, z_in, zlo_out, zhi_out,
  output logic              mar_in, mdr_in, mdr_out, read, write,
  output logic              hi_in, hi_out, lo_in, lo_out, con_in, inport_out, outport_in, r8_in,
  output logic [OP_W-1:0]   alu_op,
  output logic              run
);

  state_t          state, next;
  class_t          cls;
  ctrl_t           ctl;
  logic [OP_W-1:0] opcode;
  logic            mem_wait;
  logic            unused_ir;

  assign opcode    = ir[DATA_W-1 -: OP_W];
  assign unused_ir = ^ir[DATA_W-OP_W-1:0];

  instr_decoder #(.OP_W(OP_W)) u_dec (.opcode(opcode), .cls(cls));

  assign mem_wait = !mem_done &&
                    ((cls == C_LD && state == S_T6) || (cls == C_ST && state == S_T7));

  // Every path into T0 is an instruction boundary, where stop diverts to HALT.
  always_comb begin
    next = state;
    case (state)
      S_RST:  next = S_T0;
      S_T0:   next = S_T1;
      S_T1:   if (mem_done) next = S_T2;
      S_T2:   next = (cls == C_HALT) ? S_HALT : (cls == C_NOP) ? S_T0 : S_T3;
      S_HALT: next = S_HALT;
      default:
        if (!mem_wait) next = (state == last_step(cls)) ? S_T0 : succ(state);
    endcase
    if (next == S_T0 && stop) next = S_HALT;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_RST;
      run   <= 1'b1;
    end else begin
      state <= next;
      run   <= (next != S_HALT);
    end
  end

  // Strobes follow the state register directly so execute steps see the IR loaded in T2.
  always_comb begin
    ctl    = '0;
    alu_op = '0;
    case (state)
      S_T0: begin
        ctl.pc_out = 1'b1; ctl.mar_in = 1'b1; ctl.inc_pc = 1'b1; ctl.z_in = 1'b1;
        alu_op = OP_ADD;
      end
      S_T1: begin
        ctl.zlo_out = 1'b1; ctl.pc_in = 1'b1; ctl.read = 1'b1; ctl.mdr_in = 1'b1;
      end
      S_T2: begin
        ctl.mdr_out = 1'b1; ctl.ir_in = 1'b1;
      end
      S_T3, S_T4, S_T5, S_T6, S_T7: begin
        alu_op = (cls == C_LD || cls == C_LDI || cls == C_ST || cls == C_BR) ? OP_ADD : opcode;
        case (cls)
          C_ALU3, C_IMM: begin
            case (state)
              S_T3: begin ctl.grb = 1'b1; ctl.r_out = 1'b1; ctl.y_in = 1'b1; end
              S_T4: begin
                if (cls == C_ALU3) begin ctl.grc = 1'b1; ctl.r_out = 1'b1; end
                else ctl.c_out = 1'b1;
                ctl.z_in = 1'b1;
              end
              S_T5: begin ctl.zlo_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1; end
              default: ;
            endcase
          end
          C_ALU2: begin
            case (state)
              S_T3: begin ctl.grb = 1'b1; ctl.r_out = 1'b1; ctl.z_in = 1'b1; end
              S_T4: begin ctl.zlo_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1; end
              default: ;
            endcase
          end
          C_LDI, C_LD, C_ST: begin
            case (state)
              S_T3: begin ctl.grb = 1'b1; ctl.ba_out = 1'b1; ctl.y_in = 1'b1; end
              S_T4: begin ctl.c_out = 1'b1; ctl.z_in = 1'b1; end
              S_T5: begin
                ctl.zlo_out = 1'b1;
                if (cls == C_LDI) begin ctl.gra = 1'b1; ctl.r_in = 1'b1; end
                else ctl.mar_in = 1'b1;
              end
              S_T6: begin
                if (cls == C_LD) begin ctl.read = 1'b1; ctl.mdr_in = 1'b1; end
                else begin ctl.gra = 1'b1; ctl.r_out = 1'b1; ctl.mdr_in = 1'b1; end
              end
              S_T7: begin
                if (cls == C_LD) begin ctl.mdr_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1; end
                else ctl.write = 1'b1;
              end
              default: ;
            endcase
          end
          C_MULDIV: begin
            case (state)
              S_T3: begin ctl.gra = 1'b1; ctl.r_out = 1'b1; ctl.y_in = 1'b1; end
              S_T4: begin ctl.grb = 1'b1; ctl.r_out = 1'b1; ctl.z_in = 1'b1; end
              S_T5: begin ctl.zlo_out = 1'b1; ctl.lo_in = 1'b1; end
              S_T6: begin ctl.zhi_out = 1'b1; ctl.hi_in = 1'b1; end
              default: ;
            endcase
          end
          C_BR: begin
            case (state)
              S_T3: begin ctl.gra = 1'b1; ctl.r_out = 1'b1; ctl.con_in = 1'b1; end
              S_T4: begin ctl.pc_out = 1'b1; ctl.y_in = 1'b1; end
              S_T5: begin ctl.c_out = 1'b1; ctl.z_in = 1'b1; end
              S_T6: begin ctl.zlo_out = con_ff; ctl.pc_in = con_ff; end
              default: ;
            endcase
          end
          C_JR:   if (state == S_T3) begin ctl.gra = 1'b1; ctl.r_out = 1'b1; ctl.pc_in = 1'b1; end
          C_JAL: begin
            if (state == S_T3) begin ctl.pc_out = 1'b1; ctl.r8_in = 1'b1; end
            if (state == S_T4) begin ctl.gra = 1'b1; ctl.r_out = 1'b1; ctl.pc_in = 1'b1; end
          end
          C_IN:   if (state == S_T3) begin ctl.inport_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1; end
          C_OUT:  if (state == S_T3) begin ctl.gra = 1'b1; ctl.r_out = 1'b1; ctl.outport_in = 1'b1; end
          C_MFHI: if (state == S_T3) begin ctl.hi_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1; end
          C_MFLO: if (state == S_T3) begin ctl.lo_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign {gra, grb, grc, r_in, r_out, ba_out, c_out} =
         {ctl.gra, ctl.grb, ctl.grc, ctl.r_in, ctl.r_out, ctl.ba_out, ctl.c_out};
  assign {pc_out, pc_in, inc_pc, ir_in, y_in, z_in, zlo_out, zhi_out} =
         {ctl.pc_out, ctl.pc_in, ctl.inc_pc, ctl.ir_in, ctl.y_in, ctl.z_in, ctl.zlo_out, ctl.zhi_out};
  assign {mar_in, mdr_in, mdr_out, read, write} =
         {ctl.mar_in, ctl.mdr_in, ctl.mdr_out, ctl.read, ctl.write};
  assign {hi_in, hi_out, lo_in, lo_out, con_in, inport_out, outport_in, r8_in} =
         {ctl.hi_in, ctl.hi_out, ctl.lo_in, ctl.lo_out, ctl.con_in, ctl.inport_out,
          ctl.outport_in, ctl.r8_in};

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: each instruction is expanded into a per-cycle list of
// named strobes from the step tables, then compared cycle by cycle.
module tb_control_unit;

  logic        clock, reset, con_ff, mem_done, stop;
  logic [31:0] ir;
  logic gra, grb, grc, r_in, r_out, ba_out, c_out;
  logic pc_out, pc_in, inc_pc, ir_in, y_in, z_in, zlo_out, zhi_out;
  logic mar_in, mdr_in, mdr_out, read, write;
  logic hi_in, hi_out, lo_in, lo_out, con_in, inport_out, outport_in, r8_in;
  logic [4:0] alu_op;
  logic       run;

  int checks = 0;
  int errors = 0;

  control_unit dut (
    .clock(clock), .reset(reset), .ir(ir), .con_ff(con_ff), .mem_done(mem_done), .stop(stop),
    .gra(gra), .grb(grb), .grc(grc), .r_in(r_in), .r_out(r_out), .ba_out(ba_out), .c_out(c_out),
    .pc_out(pc_out), .pc_in(pc_in), .inc_pc(inc_pc), .ir_in(ir_in), .y_in(y_in), .z_in(z_in),
    .zlo_out(zlo_out), .zhi_out(zhi_out), .mar_in(mar_in), .mdr_in(mdr_in), .mdr_out(mdr_out),
    .read(read), .write(write), .hi_in(hi_in), .hi_out(hi_out), .lo_in(lo_in), .lo_out(lo_out),
    .con_in(con_in), .inport_out(inport_out), .outport_in(outport_in), .r8_in(r8_in),
    .alu_op(alu_op), .run(run)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  string names[28] = '{"gra", "grb", "grc", "r_in", "r_out", "ba_out", "c_out", "pc_out",
                       "pc_in", "inc_pc", "ir_in", "y_in", "z_in", "zlo_out", "zhi_out",
                       "mar_in", "mdr_in", "mdr_out", "read", "write", "hi_in", "hi_out",
                       "lo_in", "lo_out", "con_in", "inport_out", "outport_in", "r8_in"};

  logic [33:0] obs;
  assign obs = {run, alu_op, r8_in, outport_in, inport_out, con_in, lo_out, lo_in, hi_out, hi_in,
                write, read, mdr_out, mdr_in, mar_in, zhi_out, zlo_out, z_in, y_in, ir_in,
                inc_pc, pc_in, pc_out, c_out, ba_out, r_out, r_in, grc, grb, gra};

  typedef struct {
    logic [27:0] mask;
    logic [4:0]  alu;
    logic        run;
    logic        md;
  } step_t;

  step_t plan[$];

  function automatic logic [27:0] maskOf(string s);
    logic [27:0] m;
    int          start;
    string       tok;
    bit          found;
    m = '0;
    start = 0;
    for (int i = 0; i <= s.len(); i++) begin
      if (i == s.len() || s.getc(i) == 8'h20) begin
        if (i > start) begin
          tok = s.substr(start, i - 1);
          found = 1'b0;
          for (int j = 0; j < 28; j++)
            if (names[j] == tok) begin m[j] = 1'b1; found = 1'b1; end
          if (!found) $display("[TB] unknown strobe name %s", tok);
        end
        start = i + 1;
      end
    end
    return m;
  endfunction

  // A wait step lasts w cycles with mem_done low and one more with it high.
  task automatic addStep(input string s, input logic [4:0] a, input int w, input logic r = 1'b1);
    step_t st;
    st.mask = maskOf(s);
    st.alu  = a;
    st.run  = r;
    if (w < 0) begin
      st.md = 1'($urandom_range(0, 1));
      plan.push_back(st);
    end else begin
      for (int k = 0; k < w; k++) begin st.md = 1'b0; plan.push_back(st); end
      st.md = 1'b1;
      plan.push_back(st);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [33:0] got, input logic [33:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic doReset(input int n);
    reset = 1'b1; stop = 1'b0; mem_done = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(negedge clock);
      checkOutput($sformatf("reset%0d", k), obs, {1'b1, 5'd0, 28'd0});
      mem_done = 1'($urandom_range(0, 1));
    end
    reset = 1'b0; mem_done = 1'b0;
  endtask

  task automatic applyStimulus(input logic [31:0] instr, input logic cond, input int t1d,
                               input int memd, input int stopStep, input int abortAt,
                               output bit halted);
    int          op;
    logic [4:0]  ca;
    bit          halt;
    op = int'(instr[31:27]);
    ca = (op <= 2 || op == 19) ? 5'd3 : instr[31:27];
    plan.delete();
    addStep("pc_out mar_in inc_pc z_in", 5'd3, -1);
    addStep("zlo_out pc_in read mdr_in", 5'd0, t1d);
    addStep("mdr_out ir_in", 5'd0, -1);
    if (op <= 2) begin
      addStep("grb ba_out y_in", ca, -1);
      addStep("c_out z_in", ca, -1);
      if (op == 1) addStep("zlo_out gra r_in", ca, -1);
      else addStep("zlo_out mar_in", ca, -1);
      if (op == 0) begin
        addStep("read mdr_in", ca, memd);
        addStep("mdr_out gra r_in", ca, -1);
      end
      if (op == 2) begin
        addStep("gra r_out mdr_in", ca, -1);
        addStep("write", ca, memd);
      end
    end else if (op <= 11) begin
      addStep("grb r_out y_in", ca, -1);
      addStep("grc r_out z_in", ca, -1);
      addStep("zlo_out gra r_in", ca, -1);
    end else if (op <= 14) begin
      addStep("grb r_out y_in", ca, -1);
      addStep("c_out z_in", ca, -1);
      addStep("zlo_out gra r_in", ca, -1);
    end else if (op <= 16) begin
      addStep("gra r_out y_in", ca, -1);
      addStep("grb r_out z_in", ca, -1);
      addStep("zlo_out lo_in", ca, -1);
      addStep("zhi_out hi_in", ca, -1);
    end else if (op <= 18) begin
      addStep("grb r_out z_in", ca, -1);
      addStep("zlo_out gra r_in", ca, -1);
    end else if (op == 19) begin
      addStep("gra r_out con_in", ca, -1);
      addStep("pc_out y_in", ca, -1);
      addStep("c_out z_in", ca, -1);
      addStep(cond ? "zlo_out pc_in" : "", ca, -1);
    end else if (op == 20) addStep("gra r_out pc_in", ca, -1);
    else if (op == 21) begin
      addStep("pc_out r8_in", ca, -1);
      addStep("gra r_out pc_in", ca, -1);
    end
    else if (op == 22) addStep("inport_out gra r_in", ca, -1);
    else if (op == 23) addStep("gra r_out outport_in", ca, -1);
    else if (op == 24) addStep("hi_out gra r_in", ca, -1);
    else if (op == 25) addStep("lo_out gra r_in", ca, -1);
    halt = (op == 27) || (stopStep >= 0);
    if (halt) for (int k = 0; k < 3; k++) addStep("", 5'd0, -1, 1'b0);

    for (int i = 0; i < plan.size(); i++) begin
      @(negedge clock);
      checkOutput($sformatf("op%0d step%0d", op, i), obs,
                  {plan[i].run, plan[i].alu, plan[i].mask});
      if (i == 0) begin ir = instr; con_ff = cond; end
      if (i == stopStep) stop = 1'b1;
      mem_done = plan[i].md;
      if (i == abortAt) begin
        mem_done = 1'b0;
        halted = 1'b1;
        return;
      end
    end
    halted = halt;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    bit          h;
    logic [31:0] r;
    int          st;
    reset = 1'b1; ir = '0; con_ff = 1'b0; mem_done = 1'b0; stop = 1'b0;

    doReset(3);
    applyStimulus(32'h18988000, 1'b0, 0, 0, -1, -1, h);
    applyStimulus(32'h00880004, 1'b0, 1, 3, -1, -1, h);
    applyStimulus(32'h98800010, 1'b0, 0, 0, -1, -1, h);
    applyStimulus(32'h98800010, 1'b1, 2, 0, -1, -1, h);
    applyStimulus(32'hF8000000, 1'b0, 0, 0, -1, -1, h);
    applyStimulus(32'h10800020, 1'b0, 0, 2, -1, -1, h);
    applyStimulus(32'h18988000, 1'b0, 0, 0, 3, -1, h);
    doReset(2);
    applyStimulus(32'hD8000000, 1'b0, 0, 0, -1, -1, h);
    doReset(1);
    applyStimulus(32'h00880004, 1'b0, 0, 5, -1, 7, h);
    doReset(3);

    for (int n = 0; n < 150; n++) begin
      r  = $urandom;
      st = ($urandom_range(0, 19) == 0) ? 0 : -1;
      applyStimulus(r, 1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 3),
                    st, -1, h);
      if (h) doReset(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
